// File: rtl/a0_ctrl_sequencer.sv
// Control sequencer for the a0 register datapath: turns an opcode/count request
// into registered mux selects and a0 write strobes with a settle cycle before each write.
module a0_ctrl_sequencer #(
    parameter int COUNT_W = 4,
    parameter int OP_W    = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [OP_W-1:0]    opcode,
    input  logic [COUNT_W-1:0] count,
    output logic               CTRL1,
    output logic               CTRL5,
    output logic               CTRL6,
    output logic               a0_write,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_SETUP  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [OP_W-1:0]    OP_NOP   = OP_W'(3'd0);
    localparam logic [OP_W-1:0]    OP_LOAD  = OP_W'(3'd1);
    localparam logic [OP_W-1:0]    OP_MOVA1 = OP_W'(3'd2);
    localparam logic [OP_W-1:0]    OP_SUB   = OP_W'(3'd3);
    localparam logic [OP_W-1:0]    OP_SUBN  = OP_W'(3'd4);
    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t               state_r, next_state_s;
    logic [OP_W-1:0]      op_r, op_next_s;
    logic [COUNT_W-1:0]   count_r, count_next_s;
    logic [COUNT_W-1:0]   remain_r, remain_next_s, remain_dec_s;
    logic                 sel_active_s;
    logic                 ctrl1_next_s, ctrl5_next_s, ctrl6_next_s;
    logic                 a0_write_next_s, busy_next_s, done_next_s, illegal_next_s;

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op > OP_SUBN);
    endfunction

    // State, latched request and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            op_r     <= {OP_W{1'b0}};
            count_r  <= CNT_ZERO;
            remain_r <= CNT_ZERO;
            CTRL1    <= 1'b0;
            CTRL5    <= 1'b0;
            CTRL6    <= 1'b0;
            a0_write <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            op_r     <= op_next_s;
            count_r  <= count_next_s;
            remain_r <= remain_next_s;
            CTRL1    <= ctrl1_next_s;
            CTRL5    <= ctrl5_next_s;
            CTRL6    <= ctrl6_next_s;
            a0_write <= a0_write_next_s;
            busy     <= busy_next_s;
            done     <= done_next_s;
            illegal  <= illegal_next_s;
        end
    end

    // Next-state logic, plus outputs decoded from the next state so they register in step with it
    always_comb begin
        next_state_s  = state_r;
        op_next_s     = op_r;
        count_next_s  = count_r;
        remain_next_s = remain_r;
        remain_dec_s  = remain_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_next_s    = opcode;
                    count_next_s = count;
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if ((op_r == OP_NOP) || op_is_illegal(op_r) ||
                    ((op_r == OP_SUBN) && (count_r == CNT_ZERO))) begin
                    next_state_s = ST_DONE;
                end else if (op_r == OP_SUBN) begin
                    remain_next_s = count_r;
                    next_state_s  = ST_SETUP;
                end else begin
                    remain_next_s = CNT_ONE;
                    next_state_s  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                next_state_s = ST_WRITE;
            end
            ST_WRITE: begin
                // Saturating decrement: the counter never wraps below zero
                if (remain_r >= CNT_ONE) begin
                    remain_dec_s = remain_r - CNT_ONE;
                end else begin
                    remain_dec_s = remain_r;
                end
                remain_next_s = remain_dec_s;
                if (remain_dec_s != CNT_ZERO) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase

        sel_active_s    = (next_state_s == ST_SETUP) || (next_state_s == ST_WRITE);
        ctrl1_next_s    = sel_active_s && (op_r == OP_LOAD);
        ctrl5_next_s    = sel_active_s && (op_r == OP_MOVA1);
        ctrl6_next_s    = sel_active_s && ((op_r == OP_SUB) || (op_r == OP_SUBN));
        a0_write_next_s = (next_state_s == ST_WRITE);
        busy_next_s     = (next_state_s != ST_IDLE);
        done_next_s     = (next_state_s == ST_DONE);
        illegal_next_s  = (next_state_s == ST_DONE) && op_is_illegal(op_r);
    end

endmodule
